// File: rtl/tl_rx_fc_credits_received_ctrl_if.sv
// Descriptor, credit-limit and CREDITS_RECEIVED bundle between TLP decode/write handler and the FC controller.
interface tl_rx_fc_credits_received_ctrl_if #(
  parameter int unsigned HDR_CREDS_WIDTH  = 12,
  parameter int unsigned DATA_CREDS_WIDTH = 16,
  parameter int unsigned LEN_DW_WIDTH     = 10
);
  logic                          fc_init_done;
  logic                          overflow_check_en;
  logic                          tlp_valid;
  logic                          tlp_ready;
  logic [1:0]                    tlp_fc_type;
  logic                          tlp_has_data;
  logic [LEN_DW_WIDTH-1:0]       tlp_length_dw;
  logic [5:0]                    hdr_scale;
  logic [5:0]                    data_scale;
  logic [3*HDR_CREDS_WIDTH-1:0]  cl_hdr;
  logic [3*DATA_CREDS_WIDTH-1:0] cl_data;
  logic                          tlp_commit;
  logic                          overflow_error;
  logic                          overflow_is_data;
  logic [3*HDR_CREDS_WIDTH-1:0]  cr_hdr;
  logic [3*DATA_CREDS_WIDTH-1:0] cr_data;

  // Write handler side: presents descriptors and limits, consumes the verdict.
  modport master (
    output fc_init_done, overflow_check_en, tlp_valid, tlp_fc_type, tlp_has_data,
           tlp_length_dw, hdr_scale, data_scale, cl_hdr, cl_data,
    input  tlp_ready, tlp_commit, overflow_error, overflow_is_data, cr_hdr, cr_data
  );

  // Controller side.
  modport slave (
    input  fc_init_done, overflow_check_en, tlp_valid, tlp_fc_type, tlp_has_data,
           tlp_length_dw, hdr_scale, data_scale, cl_hdr, cl_data,
    output tlp_ready, tlp_commit, overflow_error, overflow_is_data, cr_hdr, cr_data
  );
endinterface

// File: rtl/tl_rx_fc_credits_received_ctrl.sv
// Receive-side FC sequencer: per-type CREDITS_RECEIVED tracking and receiver-overflow check per TLP.
module tl_rx_fc_credits_received_ctrl #(
  parameter int unsigned HDR_CREDS_WIDTH  = 12,
  parameter int unsigned DATA_CREDS_WIDTH = 16,
  parameter int unsigned LEN_DW_WIDTH     = 10
) (
  input  logic clk,
  input  logic reset_n,
  tl_rx_fc_credits_received_ctrl_if.slave bus
);

  localparam int unsigned HW = HDR_CREDS_WIDTH;
  localparam int unsigned DW = DATA_CREDS_WIDTH;
  localparam int unsigned LW = LEN_DW_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_CHECK = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      type_q, type_d;
  logic            has_data_q, has_data_d;
  logic [LW-1:0]   len_q, len_d;
  logic [1:0]      hscale_q, hscale_d;
  logic [1:0]      dscale_q, dscale_d;
  logic [DW-1:0]   need_data_q, need_data_d;
  logic [3*HW-1:0] cr_hdr_q, cr_hdr_d;
  logic [3*DW-1:0] cr_data_q, cr_data_d;
  logic            commit_q, commit_d;
  logic            ovf_q, ovf_d;
  logic            ovf_is_data_q, ovf_is_data_d;
  logic            ready_q, ready_d;

  logic [LW:0]     len_full;
  logic [DW-1:0]   need_data_calc;
  logic [3:0]      hf;
  logic [4:0]      df;
  logic [HW-1:0]   hmask, hhalf, cl_h, cr_h, sum_h, r_h, new_h;
  logic [DW-1:0]   dmask, dhalf, cl_d, cr_d, sum_d, r_d, new_d;
  logic            h_fail, d_fail;

  // Data credit need: ceil(L/G) with L=0 meaning the maximum length.
  always_comb begin
    len_full = (len_q == '0) ? {1'b1, {LW{1'b0}}} : {1'b0, len_q};
    case (dscale_q)
      2'b10:   need_data_calc = DW'((len_full + (LW+1)'(15)) >> 4);
      2'b11:   need_data_calc = DW'((len_full + (LW+1)'(63)) >> 6);
      default: need_data_calc = DW'((len_full + (LW+1)'(3)) >> 2);
    endcase
  end

  // Modular overflow check on the selected type's header and data fields.
  always_comb begin
    case (hscale_q)
      2'b10:   hf = 4'd10;
      2'b11:   hf = 4'd12;
      default: hf = 4'd8;
    endcase
    case (dscale_q)
      2'b10:   df = 5'd14;
      2'b11:   df = 5'd16;
      default: df = 5'd12;
    endcase
    hmask = ~({HW{1'b1}} << hf);
    hhalf = HW'(1) << (hf - 4'd1);
    dmask = ~({DW{1'b1}} << df);
    dhalf = DW'(1) << (df - 5'd1);

    cl_h = '0;
    cr_h = '0;
    cl_d = '0;
    cr_d = '0;
    case (type_q)
      2'd0: begin
        cl_h = bus.cl_hdr[0 +: HW];
        cr_h = cr_hdr_q[0 +: HW];
        cl_d = bus.cl_data[0 +: DW];
        cr_d = cr_data_q[0 +: DW];
      end
      2'd1: begin
        cl_h = bus.cl_hdr[HW +: HW];
        cr_h = cr_hdr_q[HW +: HW];
        cl_d = bus.cl_data[DW +: DW];
        cr_d = cr_data_q[DW +: DW];
      end
      2'd2: begin
        cl_h = bus.cl_hdr[2*HW +: HW];
        cr_h = cr_hdr_q[2*HW +: HW];
        cl_d = bus.cl_data[2*DW +: DW];
        cr_d = cr_data_q[2*DW +: DW];
      end
      default: ;
    endcase

    sum_h  = cr_h + HW'(1);
    r_h    = (cl_h - sum_h) & hmask;
    new_h  = sum_h & hmask;
    h_fail = (r_h > hhalf) && ((cl_h & hmask) != '0);

    sum_d  = cr_d + need_data_q;
    r_d    = (cl_d - sum_d) & dmask;
    new_d  = sum_d & dmask;
    d_fail = (need_data_q != '0) && (r_d > dhalf) && ((cl_d & dmask) != '0);
  end

  // Next-state, capture, counter update and pulse generation.
  always_comb begin
    state_d       = state_q;
    type_d        = type_q;
    has_data_d    = has_data_q;
    len_d         = len_q;
    hscale_d      = hscale_q;
    dscale_d      = dscale_q;
    need_data_d   = need_data_q;
    cr_hdr_d      = cr_hdr_q;
    cr_data_d     = cr_data_q;
    commit_d      = 1'b0;
    ovf_d         = 1'b0;
    ovf_is_data_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.tlp_valid && ready_q) begin
          type_d     = bus.tlp_fc_type;
          has_data_d = bus.tlp_has_data;
          len_d      = bus.tlp_length_dw;
          case (bus.tlp_fc_type)
            2'd0: begin
              hscale_d = bus.hdr_scale[1:0];
              dscale_d = bus.data_scale[1:0];
            end
            2'd1: begin
              hscale_d = bus.hdr_scale[3:2];
              dscale_d = bus.data_scale[3:2];
            end
            2'd2: begin
              hscale_d = bus.hdr_scale[5:4];
              dscale_d = bus.data_scale[5:4];
            end
            default: begin
              hscale_d = 2'b00;
              dscale_d = 2'b00;
            end
          endcase
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        need_data_d = has_data_q ? need_data_calc : '0;
        state_d     = S_CHECK;
      end
      S_CHECK: begin
        state_d = S_IDLE;
        if (type_q == 2'd3) begin
          commit_d = 1'b1;
        end else if (!bus.overflow_check_en || (!h_fail && !d_fail)) begin
          commit_d = 1'b1;
          case (type_q)
            2'd0: begin
              cr_hdr_d[0 +: HW]  = new_h;
              cr_data_d[0 +: DW] = new_d;
            end
            2'd1: begin
              cr_hdr_d[HW +: HW]  = new_h;
              cr_data_d[DW +: DW] = new_d;
            end
            default: begin
              cr_hdr_d[2*HW +: HW]  = new_h;
              cr_data_d[2*DW +: DW] = new_d;
            end
          endcase
        end else begin
          ovf_d         = 1'b1;
          ovf_is_data_d = !h_fail;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Ready only in a settled IDLE cycle, so it stays low through the cycle the verdict is visible.
    ready_d = bus.fc_init_done && (state_q == S_IDLE) && (state_d == S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      type_q        <= 2'd0;
      has_data_q    <= 1'b0;
      len_q         <= '0;
      hscale_q      <= 2'b00;
      dscale_q      <= 2'b00;
      need_data_q   <= '0;
      cr_hdr_q      <= '0;
      cr_data_q     <= '0;
      commit_q      <= 1'b0;
      ovf_q         <= 1'b0;
      ovf_is_data_q <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      type_q        <= type_d;
      has_data_q    <= has_data_d;
      len_q         <= len_d;
      hscale_q      <= hscale_d;
      dscale_q      <= dscale_d;
      need_data_q   <= need_data_d;
      cr_hdr_q      <= cr_hdr_d;
      cr_data_q     <= cr_data_d;
      commit_q      <= commit_d;
      ovf_q         <= ovf_d;
      ovf_is_data_q <= ovf_is_data_d;
      ready_q       <= ready_d;
    end
  end

  assign bus.tlp_ready        = ready_q;
  assign bus.tlp_commit       = commit_q;
  assign bus.overflow_error   = ovf_q;
  assign bus.overflow_is_data = ovf_is_data_q;
  assign bus.cr_hdr           = cr_hdr_q;
  assign bus.cr_data          = cr_data_q;

endmodule

// File: tb/tb_tl_rx_fc_credits_received_ctrl.sv
// Self-checking bench: vector table plus reset and wrap sequences, verdicts checked through a scoreboard queue.
module tb_tl_rx_fc_credits_received_ctrl;

  localparam int unsigned HW = 12;
  localparam int unsigned DW = 16;
  localparam int unsigned LW = 10;
  localparam int unsigned NVEC = 19;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  tl_rx_fc_credits_received_ctrl_if #(
    .HDR_CREDS_WIDTH(HW), .DATA_CREDS_WIDTH(DW), .LEN_DW_WIDTH(LW)
  ) bus ();

  tl_rx_fc_credits_received_ctrl #(
    .HDR_CREDS_WIDTH(HW), .DATA_CREDS_WIDTH(DW), .LEN_DW_WIDTH(LW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  typedef struct {
    logic [1:0]    typ;
    logic          has_data;
    logic [LW-1:0] len;
    logic [1:0]    hs;
    logic [1:0]    ds;
    logic [HW-1:0] clh;
    logic [DW-1:0] cld;
    logic          en;
    logic          exp_commit;
    logic          exp_is_data;
    logic [HW-1:0] exp_h;
    logic [DW-1:0] exp_d;
  } vec_t;

  typedef struct {
    logic            commit;
    logic            is_data;
    logic [3*HW-1:0] cr_h;
    logic [3*DW-1:0] cr_d;
    int unsigned     acc;
  } exp_t;

  exp_t          sbq[$];
  exp_t          mon_e;
  vec_t          tbl[NVEC];
  logic [HW-1:0] sh_h[3];
  logic [DW-1:0] sh_d[3];
  int unsigned   cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int typ, input int hd, input int len, input int hs, input int ds,
                              input int clh, input int cld, input int en, input int c, input int isd,
                              input int eh, input int ed);
    vec_t v;
    v.typ = 2'(typ);  v.has_data = 1'(hd);  v.len = LW'(len);
    v.hs = 2'(hs);    v.ds = 2'(ds);
    v.clh = HW'(clh); v.cld = DW'(cld);     v.en = 1'(en);
    v.exp_commit = 1'(c); v.exp_is_data = 1'(isd);
    v.exp_h = HW'(eh); v.exp_d = DW'(ed);
    return v;
  endfunction

  function automatic logic [3*HW-1:0] pack_h();
    return {sh_h[2], sh_h[1], sh_h[0]};
  endfunction

  function automatic logic [3*DW-1:0] pack_d();
    return {sh_d[2], sh_d[1], sh_d[0]};
  endfunction

  // Verdict monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && (bus.tlp_commit || bus.overflow_error)) begin
      chk("pulse_exclusive", 64'(bus.tlp_commit & bus.overflow_error), 64'd0);
      chk("pulse_expected", 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        chk("tlp_commit", 64'(bus.tlp_commit), 64'(mon_e.commit));
        chk("overflow_error", 64'(bus.overflow_error), 64'(!mon_e.commit));
        if (!mon_e.commit) chk("overflow_is_data", 64'(bus.overflow_is_data), 64'(mon_e.is_data));
        chk("cr_hdr", 64'(bus.cr_hdr), 64'(mon_e.cr_h));
        chk("cr_data", 64'(bus.cr_data), 64'(mon_e.cr_d));
        chk("verdict_latency", 64'(cyc - mon_e.acc), 64'd3);
      end
    end
  end

  task automatic drive(input vec_t v);
    int t;
    t = int'(v.typ);
    bus.tlp_fc_type       = v.typ;
    bus.tlp_has_data      = v.has_data;
    bus.tlp_length_dw     = v.len;
    bus.overflow_check_en = v.en;
    bus.hdr_scale         = '0;
    bus.data_scale        = '0;
    bus.cl_hdr            = '0;
    bus.cl_data           = '0;
    if (t != 3) begin
      bus.hdr_scale[2*t +: 2] = v.hs;
      bus.data_scale[2*t +: 2] = v.ds;
      bus.cl_hdr[HW*t +: HW]  = v.clh;
      bus.cl_data[DW*t +: DW] = v.cld;
    end
  endtask

  task automatic send(input vec_t v, input string tag);
    bit   got;
    exp_t e;
    drive(v);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.tlp_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk($sformatf("%s_ready", tag), 64'(got), 64'd1);
    if (!got) return;
    bus.tlp_valid = 1'b1;
    if (v.typ != 2'd3) begin
      sh_h[v.typ] = v.exp_h;
      sh_d[v.typ] = v.exp_d;
    end
    e.commit = v.exp_commit;
    e.is_data = v.exp_is_data;
    e.cr_h = pack_h();
    e.cr_d = pack_d();
    e.acc = cyc;
    sbq.push_back(e);
    @(posedge clk);
    #1 bus.tlp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("%s_busy", tag), 64'(bus.tlp_ready), 64'd0);
    end
    for (int k = 0; k < 10; k++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    chk($sformatf("%s_verdict_seen", tag), 64'(sbq.size()), 64'd0);
    sbq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // typ hd len hs ds clh cld en | commit is_data exp_h exp_d (field of that type after the TLP)
    tbl[0]  = mk(0, 1, 16,  1, 1, 'h10,  'h40,  1, 1, 0, 1, 4);
    tbl[1]  = mk(0, 1, 16,  1, 1, 'h10,  'h40,  1, 1, 0, 2, 8);
    tbl[2]  = mk(0, 1, 16,  1, 1, 'h10,  'h40,  1, 1, 0, 3, 12);
    tbl[3]  = mk(0, 1, 16,  1, 1, 'h10,  'h40,  1, 1, 0, 4, 16);
    tbl[4]  = mk(1, 0, 0,   1, 1, 'h02,  0,     1, 1, 0, 1, 0);
    tbl[5]  = mk(1, 0, 0,   1, 1, 'h02,  0,     1, 1, 0, 2, 0);
    tbl[6]  = mk(1, 0, 0,   1, 1, 'h02,  0,     1, 0, 0, 2, 0);
    tbl[7]  = mk(2, 1, 17,  1, 2, 0,     'h100, 1, 1, 0, 1, 2);
    tbl[8]  = mk(2, 1, 0,   1, 2, 0,     'h100, 1, 1, 0, 2, 66);
    tbl[9]  = mk(2, 1, 256, 1, 2, 0,     'h50,  1, 0, 1, 2, 66);
    tbl[10] = mk(1, 1, 8,   1, 1, 'h02,  'h01,  1, 0, 0, 2, 0);
    tbl[11] = mk(0, 1, 0,   1, 1, 'h10,  0,     1, 1, 0, 5, 272);
    tbl[12] = mk(1, 0, 0,   1, 1, 'h02,  0,     0, 1, 0, 3, 0);
    tbl[13] = mk(3, 1, 4,   0, 0, 0,     0,     1, 1, 0, 0, 0);
    tbl[14] = mk(0, 0, 0,   2, 1, 'h206, 0,     1, 1, 0, 6, 272);
    tbl[15] = mk(0, 0, 0,   1, 1, 'h206, 0,     1, 0, 0, 6, 272);
    tbl[16] = mk(1, 0, 0,   3, 1, 'h800, 0,     1, 1, 0, 4, 0);
    tbl[17] = mk(1, 0, 0,   3, 1, 'h003, 0,     1, 0, 0, 4, 0);
    tbl[18] = mk(2, 1, 65,  1, 3, 0,     0,     1, 1, 0, 3, 68);

    for (int i = 0; i < 3; i++) begin
      sh_h[i] = '0;
      sh_d[i] = '0;
    end
    bus.fc_init_done = 1'b0;
    bus.tlp_valid    = 1'b0;
    drive(tbl[0]);

    // Power-on reset.
    reset_n = 1'b0;
    #1;
    chk("rst_cr_hdr", 64'(bus.cr_hdr), 64'd0);
    chk("rst_cr_data", 64'(bus.cr_data), 64'd0);
    chk("rst_commit", 64'(bus.tlp_commit), 64'd0);
    chk("rst_overflow", 64'(bus.overflow_error), 64'd0);
    chk("rst_is_data", 64'(bus.overflow_is_data), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("ready_before_init", 64'(bus.tlp_ready), 64'd0);
    bus.fc_init_done = 1'b1;
    @(negedge clk);
    chk("ready_after_init", 64'(bus.tlp_ready), 64'd1);

    // Vector table.
    for (int i = 0; i < int'(NVEC); i++) send(tbl[i], $sformatf("vec%0d", i));

    // Reset while a TLP is in CALC: no verdict, counters cleared, ready gated by fc_init_done.
    drive(tbl[0]);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.tlp_ready === 1'b1) break;
    end
    bus.tlp_valid = 1'b1;
    @(posedge clk);
    #1 bus.tlp_valid = 1'b0;
    #1 reset_n = 1'b0;
    bus.fc_init_done = 1'b0;
    #1;
    chk("midrst_cr_hdr", 64'(bus.cr_hdr), 64'd0);
    chk("midrst_cr_data", 64'(bus.cr_data), 64'd0);
    chk("midrst_ready", 64'(bus.tlp_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midrst_no_pulse", 64'(bus.tlp_commit | bus.overflow_error), 64'd0);
    end
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midrst_ready_held", 64'(bus.tlp_ready), 64'd0);
      chk("midrst_no_pulse_after", 64'(bus.tlp_commit | bus.overflow_error), 64'd0);
    end
    chk("midrst_cr_hdr_after", 64'(bus.cr_hdr), 64'd0);
    bus.fc_init_done = 1'b1;
    @(negedge clk);
    chk("midrst_ready_init", 64'(bus.tlp_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      sh_h[i] = '0;
      sh_d[i] = '0;
    end

    // Preload P header counter to 0xFF with infinite limit, then wrap it against a finite limit.
    for (int i = 0; i < 255; i++)
      send(mk(0, 0, 0, 1, 1, 0, 0, 1, 1, 0, i + 1, 0), "preload");
    send(mk(0, 0, 0, 1, 1, 'h7F, 0, 1, 1, 0, 0, 0), "wrap");
    chk("wrap_cr_hdr_p", 64'(bus.cr_hdr[HW-1:0]), 64'd0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_rx_fc_credits_received_ctrl.md
# tl_rx_fc_credits_received_ctrl

Sequencer for receive-side flow control: per FC type (Posted, Non-Posted, Completion), it tracks the CREDITS_RECEIVED counters for header and data, and checks each incoming TLP for receiver overflow against the advertised credit limits. It sits in the TL RX write handler, between TLP header decode and buffer write. It tells the write handler whether to commit or drop each TLP. Each check takes three cycles; on a pass the counter update is atomic with the commit.

## Interface
Parameters:
- HDR_CREDS_WIDTH, 12, width of each header counter/limit field
- DATA_CREDS_WIDTH, 16, width of each data counter/limit field
- LEN_DW_WIDTH, 10, TLP length field width (0 encodes 1024 DW)

Ports:
- clk  in  1  clock (all logic rising-edge)
- reset_n  in  1  asynchronous active-low reset
- fc_init_done  in  1  FC initialization complete; gates acceptance
- overflow_check_en  in  1  enables overflow checking
- tlp_valid  in  1  TLP descriptor valid
- tlp_ready  out  1  controller can take a descriptor
- tlp_fc_type  in  2  00 P, 01 NP, 10 Cpl, 11 reserved
- tlp_has_data  in  1  TLP carries payload
- tlp_length_dw  in  LEN_DW_WIDTH  payload length in DW
- hdr_scale  in  6  {Cpl,NP,P} 2-bit HdrScale each
- data_scale  in  6  {Cpl,NP,P} 2-bit DataScale each
- cl_hdr  in  3*HDR_CREDS_WIDTH  advertised header limits {Cpl,NP,P}
- cl_data  in  3*DATA_CREDS_WIDTH  advertised data limits {Cpl,NP,P}
- tlp_commit  out  1  one-cycle pulse: TLP accepted, counters updated
- overflow_error  out  1  one-cycle pulse: TLP overflowed, dropped
- overflow_is_data  out  1  valid with overflow_error: 1 = data field failed (hdr has priority if both)
- cr_hdr  out  3*HDR_CREDS_WIDTH  CREDITS_RECEIVED header {Cpl,NP,P}
- cr_data  out  3*DATA_CREDS_WIDTH  CREDITS_RECEIVED data {Cpl,NP,P}

## Operation
- FSM states: IDLE, CALC, CHECK.
- IDLE: tlp_ready = fc_init_done. On tlp_valid & tlp_ready, capture the type, has_data, length and the selected scales, then go to CALC.
- CALC: compute the credit need and register it.
  - need_hdr = 1.
  - need_data = 0 if !has_data. Otherwise ceil(L/G), where L = length (0 → 1024) and G = 4 DW for scale 00/01, 16 for 10, 64 for 11.
  - Go to CHECK.
- CHECK: field width F depends on scale.
  - Header: F = 8 for 00/01, 10 for 10, 12 for 11.
  - Data: F = 12 for 00/01, 14 for 10, 16 for 11.
  - Compute R = (CL − (CR + need)) mod 2^F.
  - A field fails if R > 2^(F−1).
  - A field is exempt if its CL[F−1:0] == 0 (infinite credits).
  - The data field is checked only if need_data ≠ 0.
- CHECK outcome:
  - No failure, or overflow_check_en = 0: CR ← (CR + need) mod 2^F, with bits above F cleared; tlp_commit = 1.
  - Otherwise: overflow_error = 1; CR unchanged.
  - Return to IDLE.
- Reserved type 11: no check, no counter change; tlp_commit pulses in CHECK.
- overflow_check_en and cl_* are sampled in the CHECK cycle. Scales are captured at acceptance.
- Reset (asynchronous, any state):
  - FSM goes to IDLE and all CR fields clear to 0.
  - tlp_commit, overflow_error and overflow_is_data go to 0.
  - tlp_ready reads 0 until fc_init_done is asserted.
  - Any in-flight TLP is abandoned with no pulse.

## Timing
- Accept in cycle T. CALC is T+1. Pulses and CR update are registered in the CHECK cycle and visible at T+3.
- tlp_ready is low from T+1 to T+3, so there is at most one TLP per 3 cycles and back-to-back accepts cannot occur.
- Pulses are exactly one cycle. tlp_commit and overflow_error are never high together.
- cr_* are registered and change only on the commit edge.
- If fc_init_done drops mid-flight, the in-flight TLP completes; acceptance is blocked afterwards.
- Wrap-around: CR wraps mod 2^F silently. This is not an error by itself.

## Test plan
- Count, data: reset, fc_init_done = 1, P scales 01, cl_hdr.P = 0x10, cl_data.P = 0x40. Send 4 P TLPs with 16 DW each. Required: 4 commits; cr_hdr.P = 4; cr_data.P = 16; each commit exactly 3 cycles after its accept.
- Header overflow: NP with cl_hdr.NP = 0x02, scale 01. Send 3 NP TLPs with no data. Required: commits 1–2; the 3rd gives overflow_error = 1, overflow_is_data = 0, and cr_hdr.NP stays 2.
- Count, rounding: Cpl with data scale 10 and length 17 DW gives need_data = 2. Length 0 gives 1024/16 = 64. Required: cr_data.Cpl = 66 after both TLPs.
- Infinite and disabled: with cl_data.P = 0, a 1024 DW P TLP commits. With overflow_check_en = 0 and cl_hdr exhausted, a TLP commits and CR still increments.
- Wrap: scale 01 with cr_hdr.P preloaded to 0xFF by 255 commits, cl_hdr.P = 0x7F. Required: the next TLP commits and cr_hdr.P = 0x00, bits above 7 zero.
- Reset mid-operation: assert reset_n = 0 during CALC. Required: no pulse; all cr_* = 0; tlp_ready low until fc_init_done is high after release.
